// File: rtl/dct_2d_seq.sv
// dct_2d_seq: step/enable sequencer for a row-DCT, transpose, column-DCT pipeline
// with output framing and a flush path that zero-pads a partial block and drains.
module dct_2d_seq #(
    parameter int N       = 8,
    parameter int DCT_LAT = 48,
    parameter int TRB_LAT = 64,
    parameter int CW      = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    output logic in_ready,
    input  logic flush,
    output logic dct1_ena,
    output logic trb_ena,
    output logic dct2_ena,
    output logic pad,
    output logic step,
    output logic out_valid,
    output logic out_first,
    output logic block_done,
    output logic busy
);
    localparam int NN = N * N;
    localparam int IW = (NN > 1) ? $clog2(NN) : 1;
    localparam logic [IW-1:0] LAST   = IW'(NN - 1);
    localparam logic [CW-1:0] T_TRB  = CW'(DCT_LAT - 1);
    localparam logic [CW-1:0] T_DCT2 = CW'(DCT_LAT + TRB_LAT + 1);
    localparam logic [CW-1:0] T_OUT  = CW'(2 * DCT_LAT + TRB_LAT + 1);
    localparam logic [CW-1:0] F_MAX  = CW'(2 * DCT_LAT + TRB_LAT + 2);

    typedef enum logic [1:0] {IDLE, RUN, PAD, DRAIN} state_t;

    state_t state, state_n;
    logic [CW-1:0] f, f_n, pend, pend_n;
    logic [IW-1:0] ii, ii_n, oi;
    logic acc, emit, wrap, done;

    always_comb begin
        in_ready   = state == IDLE || state == RUN;
        pad        = state == PAD;
        busy       = state != IDLE;
        acc        = (in_valid && in_ready) || pad;
        step       = acc || state == DRAIN;
        wrap       = acc && ii == LAST;
        ii_n       = acc ? (wrap ? '0 : ii + 1'b1) : ii;
        f_n        = (step && f != F_MAX) ? f + 1'b1 : f;
        // once drained, further DRAIN steps must not emit phantom samples
        emit       = step && f_n > T_OUT && (state != DRAIN || pend != '0);
        pend_n     = pend + CW'(acc) - CW'(emit);
        done       = state == DRAIN && pend == '0;
        state_n    = state == IDLE ? (acc ? RUN : IDLE)
                   : state == RUN  ? (flush ? (ii_n == '0 ? DRAIN : PAD) : RUN)
                   : state == PAD  ? (wrap ? DRAIN : PAD)
                   : (done ? IDLE : DRAIN);
        out_first  = out_valid && oi == '0;
        block_done = out_valid && oi == LAST;
    end

    always_ff @(posedge clk) begin
        if (rst || done) begin
            state     <= IDLE;
            f         <= '0;
            ii        <= '0;
            oi        <= '0;
            pend      <= '0;
            out_valid <= 1'b0;
            dct1_ena  <= 1'b0;
            trb_ena   <= 1'b0;
            dct2_ena  <= 1'b0;
        end else begin
            state     <= state_n;
            f         <= f_n;
            ii        <= ii_n;
            pend      <= pend_n;
            oi        <= out_valid ? (oi == LAST ? '0 : oi + 1'b1) : oi;
            out_valid <= emit;
            dct1_ena  <= dct1_ena | acc;
            trb_ena   <= trb_ena | (step && f_n >= T_TRB);
            dct2_ena  <= dct2_ena | (step && f_n >= T_DCT2);
        end
    end
endmodule

// File: tb/tb_dct_2d_seq.sv
// tb_dct_2d_seq: directed bench for dct_2d_seq with a sample/step-counting reference model.
module tb_dct_2d_seq;
    localparam int NN     = 64;
    localparam int DLAT   = 48;
    localparam int TLAT   = 64;
    localparam int T_TRB  = DLAT - 1;
    localparam int T_DCT2 = DLAT + TLAT + 1;
    localparam int T_OUT  = T_DCT2 + DLAT;

    logic clk = 0, rst = 1, in_valid = 0, flush = 0;
    logic in_ready, dct1_ena, trb_ena, dct2_ena, pad, step, out_valid, out_first, block_done, busy;

    dct_2d_seq dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
        .dct1_ena(dct1_ena), .trb_ena(trb_ena), .dct2_ena(dct2_ena), .pad(pad), .step(step),
        .out_valid(out_valid), .out_first(out_first), .block_done(block_done), .busy(busy)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0, cyc = 0;
    bit started = 0;

    // Reference model: mode 0 idle, 1 run, 2 pad, 3 drain; counts steps, accepted and emitted samples.
    int m_mode = 0, m_steps = 0, m_acc = 0, m_emit = 0;
    logic m_ov = 0, m_first = 0, m_done = 0;

    always @(posedge clk) begin
        bit a, s;
        a = (in_valid && m_mode <= 1) || m_mode == 2;
        s = a || m_mode == 3;
        m_ov = 0; m_first = 0; m_done = 0;
        if (rst || (m_mode == 3 && m_acc == m_emit)) begin
            m_mode = 0; m_steps = 0; m_acc = 0; m_emit = 0;
        end else begin
            if (a) m_acc++;
            if (s) m_steps++;
            if (s && m_steps > T_OUT && m_emit < m_acc) begin
                m_ov = 1;
                m_first = (m_emit % NN) == 0;
                m_done = (m_emit % NN) == NN - 1;
                m_emit++;
            end
            if (m_mode == 0 && a) m_mode = 1;
            else if (m_mode == 1 && flush) m_mode = (m_acc % NN == 0) ? 3 : 2;
            else if (m_mode == 2 && m_acc % NN == 0) m_mode = 3;
        end
    end

    int out_cnt, pad_cnt, steps, s162, done_idx, r1, r2, r3, ro, en_drop;
    int firsts[$];
    logic [2:0] e_prev;

    always @(negedge clk) begin
        logic [9:0] got, exp;
        bit ir;
        if (started) begin
            ir = m_mode <= 1;
            exp = {ir, (in_valid && ir) || m_mode >= 2, m_mode == 2, m_mode != 0,
                   m_steps >= 1, m_steps >= T_TRB, m_steps >= T_DCT2, m_ov, m_first, m_done};
            got = {in_ready, step, pad, busy, dct1_ena, trb_ena, dct2_ena, out_valid, out_first, block_done};
            tests++;
            if (got !== exp) begin
                fails++;
                $display("FAIL cycle_cmp cyc=%0d got=%b exp=%b", cyc, got, exp);
            end
            if (dct1_ena && r1 == 0) r1 = cyc;
            if (trb_ena && r2 == 0) r2 = cyc;
            if (dct2_ena && r3 == 0) r3 = cyc;
            if (out_valid && ro == 0) ro = cyc;
            if (out_valid) begin
                if (out_first) firsts.push_back(out_cnt);
                if (block_done) done_idx = out_cnt;
                out_cnt++;
            end
            if (pad) pad_cnt++;
            if (step) begin
                steps++;
                if (steps == T_OUT + 1) s162 = cyc;
            end
            if (busy && (e_prev & ~{dct1_ena, trb_ena, dct2_ena}) != 0) en_drop++;
            e_prev = {dct1_ena, trb_ena, dct2_ena};
        end
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1 cyc++;
    endtask

    task automatic do_reset(input int n);
        rst = 1; in_valid = 0; flush = 0;
        repeat (n) tick;
        rst = 0; cyc = 0;
        out_cnt = 0; pad_cnt = 0; steps = 0; s162 = 0; done_idx = -1;
        r1 = 0; r2 = 0; r3 = 0; ro = 0; en_drop = 0; firsts.delete();
        started = 1;
        check("reset_outputs",
              int'({in_ready, step, pad, busy, dct1_ena, trb_ena, dct2_ena, out_valid, out_first, block_done}),
              10'b1000000000);
    endtask

    task automatic feed(input int n, input bit flush_last);
        for (int k = 1; k <= n; k++) begin
            tick;
            in_valid = 1;
            flush = flush_last && k == n;
        end
    endtask

    task automatic run_idle(input int limit);
        int i;
        for (i = 0; i < limit; i++) begin
            tick;
            in_valid = 0; flush = 0;
            if (!busy) break;
        end
        check("idle_reached", int'(busy), 0);
    endtask

    initial begin
        int acc, guard;
        do_reset(2);
        feed(64, 1);
        run_idle(400);
        check("dct1_rise", r1, 2);
        check("trb_rise", r2, 48);
        check("dct2_rise", r3, 114);
        check("first_out_cycle", ro, 163);
        check("first_is_first", firsts.size() > 0 ? firsts[0] : -1, 0);
        check("one_block_outputs", out_cnt, 64);
        check("block_done_idx", done_idx, 63);

        do_reset(2);
        feed(192, 1);
        run_idle(500);
        check("three_block_outputs", out_cnt, 192);
        check("three_block_firsts", firsts.size(), 3);
        check("second_first_idx", firsts.size() == 3 ? firsts[1] : -1, 64);
        check("third_first_idx", firsts.size() == 3 ? firsts[2] : -1, 128);
        check("three_block_pad", pad_cnt, 0);

        do_reset(2);
        feed(20, 0);
        tick;
        in_valid = 0; flush = 1;
        run_idle(400);
        check("partial_pad_cycles", pad_cnt, 44);
        check("partial_outputs", out_cnt, 64);

        do_reset(2);
        acc = 0; guard = 0;
        while (acc < 128 && guard < 2000) begin
            tick;
            in_valid = $urandom_range(0, 1);
            flush = in_valid && acc == 127;
            if (in_valid) acc++;
            guard++;
        end
        run_idle(600);
        check("gap_outputs", out_cnt, 128);
        check("gap_first_after_162", ro, s162 + 1);
        check("gap_enable_drop", en_drop, 0);

        do_reset(2);
        feed(63, 0);
        tick;
        in_valid = 1; flush = 1;
        repeat (20) begin
            tick;
            in_valid = 1; flush = 0;
        end
        run_idle(400);
        check("joint_flush_pad", pad_cnt, 0);
        check("joint_flush_outputs", out_cnt, 64);

        do_reset(2);
        feed(64, 1);
        repeat (30) begin
            tick;
            in_valid = 0; flush = 0;
        end
        check("busy_before_rst", int'(busy), 1);
        do_reset(1);
        feed(64, 1);
        run_idle(400);
        check("restart_dct1_rise", r1, 2);
        check("restart_outputs", out_cnt, 64);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
